// File: rtl/mgt_01_mul_ip.sv
// Four-stage pipelined 32x32 multiplier returning the low or high product half (MUL/MULH/MULHSU/MULHU).
// Latency: 4 enabled clock edges from operand sampling to result_o; one new operation per enabled cycle.
// Backpressure: none; clk_en_i = 0 freezes every stage, including result_o and in-flight data.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset; clears all stages and overrides clk_en_i
//   clk_en_i       pipeline enable (0 = stall)
//   multiplicand_i rs1 operand
//   multiplier_i   rs2 operand
//   ops_i          0 = MUL, 1 = MULH, 2 = MULHSU, 3 = MULHU
//   result_o       selected 32-bit product half, registered
// Optional build macro MGT_MUL_VALID_EN adds valid_i / valid_o, a 4-deep valid
// shift register that is stalled and reset together with the datapath.

module mgt_01_mul_ip #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clk_en_i,
    input  logic [DATA_W-1:0] multiplicand_i,
    input  logic [DATA_W-1:0] multiplier_i,
    input  logic [1:0]        ops_i,
`ifdef MGT_MUL_VALID_EN
    input  logic              valid_i,
    output logic              valid_o,
`endif
    output logic [DATA_W-1:0] result_o
);

    localparam logic [1:0] MUL_    = 2'd0;
    localparam logic [1:0] MULH_   = 2'd1;
    localparam logic [1:0] MULHSU_ = 2'd2;
    localparam logic [1:0] MULHU_  = 2'd3;

    // The partial-product split below is hard-wired for 32-bit operands.
    if (DATA_W != 32 || LATENCY != 4) begin : g_bad_params
        $error("mgt_01_mul_ip supports only DATA_W=32, LATENCY=4");
    end

    // ---------------- operand extension to 33 bits ----------------
    // The multiplicand is unsigned only for MULHU; the multiplier is signed
    // only for MUL and MULH. The low half of MUL is signedness-independent.
    logic a_sign;
    logic b_sign;
    assign a_sign = (ops_i != MULHU_) & multiplicand_i[31];
    assign b_sign = ((ops_i == MUL_) | (ops_i == MULH_)) & multiplier_i[31];

    // ---------------- stage 1: extended operands ----------------
    logic signed [32:0] a1;
    logic signed [32:0] b1;
    logic [1:0]         op1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a1  <= '0;
            b1  <= '0;
            op1 <= MUL_;
        end else if (clk_en_i) begin
            a1  <= {a_sign, multiplicand_i};
            b1  <= {b_sign, multiplier_i};
            op1 <= ops_i;
        end
    end

    // ---------------- stage 2: two 33x17 signed partial products ----------------
    // Multiplier = b_hi * 2^16 + b_lo, with b_hi = b1[32:16] signed and
    // b_lo = b1[15:0] unsigned (zero-extended to keep it non-negative).
    // Operands are widened to 50 bits so each product is exact.
    logic signed [49:0] a_x50;
    logic signed [49:0] bh_x50;
    logic signed [49:0] bl_x50;
    assign a_x50  = {{17{a1[32]}}, a1};
    assign bh_x50 = {{33{b1[32]}}, b1[32:16]};
    assign bl_x50 = {34'd0, b1[15:0]};

    logic signed [49:0] pp_hi2;
    logic signed [49:0] pp_lo2;
    logic [1:0]         op2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pp_hi2 <= '0;
            pp_lo2 <= '0;
            op2    <= MUL_;
        end else if (clk_en_i) begin
            pp_hi2 <= a_x50 * bh_x50;
            pp_lo2 <= a_x50 * bl_x50;
            op2    <= op1;
        end
    end

    // ---------------- stage 3: align and sum into 66-bit product ----------------
    logic signed [65:0] prod_sum;
    assign prod_sum = {pp_hi2, 16'd0} + {{16{pp_lo2[49]}}, pp_lo2};

    logic signed [65:0] prod3;
    logic [1:0]         op3;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod3 <= '0;
            op3   <= MUL_;
        end else if (clk_en_i) begin
            prod3 <= prod_sum;
            op3   <= op2;
        end
    end

    // Bits 65:64 only carry the sign extension of a 33x33 product.
    logic prod_top_unused;
    assign prod_top_unused = ^prod3[65:64];

    // ---------------- stage 4: half select ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o <= '0;
        end else if (clk_en_i) begin
            result_o <= (op3 == MUL_) ? prod3[31:0] : prod3[63:32];
        end
    end

`ifdef MGT_MUL_VALID_EN
    // Valid marker travelling alongside the data, same stall/reset behaviour.
    logic [LATENCY-1:0] vld_sr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_sr <= '0;
        end else if (clk_en_i) begin
            vld_sr <= {vld_sr[LATENCY-2:0], valid_i};
        end
    end

    assign valid_o = vld_sr[LATENCY-1];
`endif

endmodule

// File: tb/tb_mgt_01_mul_ip.sv
module tb_mgt_01_mul_ip;

    localparam logic [1:0] MUL_    = 2'd0;
    localparam logic [1:0] MULH_   = 2'd1;
    localparam logic [1:0] MULHSU_ = 2'd2;
    localparam logic [1:0] MULHU_  = 2'd3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clk_en_i = 1'b0;
    logic [31:0] multiplicand_i = '0;
    logic [31:0] multiplier_i = '0;
    logic [1:0]  ops_i = MUL_;
    logic [31:0] result_o;
    logic        valid_i = 1'b0;
`ifdef MGT_MUL_VALID_EN
    logic        valid_o;
`endif

    mgt_01_mul_ip dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clk_en_i       (clk_en_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .ops_i          (ops_i),
`ifdef MGT_MUL_VALID_EN
        .valid_i        (valid_i),
        .valid_o        (valid_o),
`endif
        .result_o       (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          en;
        bit          vld;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        bit          vld;
        string       name;
    } sb_t;

    int   checks = 0;
    int   failures = 0;
    sb_t  sbq[$];
    logic [31:0] last_exp = '0;
    bit   last_vld = 1'b0;
    vec_t vecs[$];

    // Reference: full 66-bit product of the operands extended per op.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ae;
        logic signed [65:0] be;
        logic signed [65:0] p;
        ae = (op == MULHU_) ? {34'd0, a} : {{34{a[31]}}, a};
        be = (op == MUL_ || op == MULH_) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ae * be;
        return (op == MUL_) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: result_o=0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_vld(input string nm, input bit exp);
`ifdef MGT_MUL_VALID_EN
        checks++;
        if (valid_o !== exp) begin
            failures++;
            $display("FAIL %s valid: valid_o=%0b expected %0b at %0t", nm, valid_o, exp, $time);
        end
`else
        if (nm.len() == 0 && exp) last_vld = last_vld;
`endif
    endtask

    // Drive one cycle, clock it, then compare result_o a little after the edge.
    // Every enabled sample is scoreboarded; an entry pops on the 4th enabled edge.
    task automatic step(input bit en, input bit vld, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm);
        sb_t e;
        clk_en_i       = en;
        valid_i        = vld;
        ops_i          = op;
        multiplicand_i = a;
        multiplier_i   = b;
        @(posedge clk_i);
        #1;
        if (en) begin
            e.exp = exp; e.vld = vld; e.name = nm;
            sbq.push_back(e);
            if (sbq.size() == 4) begin
                e = sbq.pop_front();
                last_exp = e.exp;
                last_vld = e.vld;
                check(e.name, result_o, last_exp);
                check_vld(e.name, last_vld);
                return;
            end
        end
        check(en ? "fill/hold" : "stall_hold", result_o, last_exp);
        check_vld("hold", last_vld);
    endtask

    task automatic add(input bit en, input bit vld, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm);
        vec_t v;
        v.en = en; v.vld = vld; v.op = op; v.a = a; v.b = b; v.exp = exp; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic bubble(input bit en);
        add(en, 1'b0, MUL_, 32'd0, 32'd0, 32'd0, "bubble");
    endtask

    initial begin
        // Reset state
        #1;
        check("reset_state", result_o, 32'd0);
        check_vld("reset_state", 1'b0);
        @(posedge clk_i); #1;
        clk_en_i = 1'b1;
        @(posedge clk_i); #1;
        check("reset_overrides_en", result_o, 32'd0);
        rst_i = 1'b0;

        // Vector table
        add(1, 1, MUL_, 32'd9, 32'd10, 32'h0000005A, "stream0");
        add(1, 1, MUL_, -32'sd12, 32'd10, 32'hFFFFFF88, "stream1");
        add(1, 1, MUL_, -32'sd100, 32'd10, 32'hFFFFFC18, "stream2");
        bubble(1); bubble(1); bubble(1);
        add(1, 1, MUL_, 32'd1000, 32'd0, 32'h00000000, "sparse0");
        bubble(1); bubble(1); bubble(1);
        add(1, 1, MUL_, 32'd10000, 32'd2, 32'h00004E20, "sparse1");
        add(1, 1, MULH_, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
        add(1, 1, MULHU_, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
        add(1, 1, MULHSU_, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
        add(1, 1, MULH_, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1");
        add(1, 1, MUL_, -32'sd2, 32'd3, 32'hFFFFFFFA, "mix_mul");
        add(1, 1, MULHU_, -32'sd2, 32'd3, 32'h00000002, "mix_mulhu");
        add(1, 1, MULH_, -32'sd2, 32'd3, 32'hFFFFFFFF, "mix_mulh");
        add(1, 1, MUL_, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mul_wrap");
        bubble(1); bubble(1); bubble(1);
        // Stall mid-flight: (9,10) sampled, one more enabled edge, 3 stalled cycles
        add(1, 1, MUL_, 32'd9, 32'd10, 32'h0000005A, "stall_op");
        bubble(1);
        bubble(0); bubble(0); bubble(0);
        bubble(1); bubble(1); bubble(1); bubble(1);

        foreach (vecs[i])
            step(vecs[i].en, vecs[i].vld, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        // Asynchronous reset with operations in flight
        step(1, 1, MULHU_, 32'hFFFFFFFF, 32'h12345678, 32'h12345677, "pre_rst0");
        step(1, 1, MUL_, 32'd7, 32'd6, 32'd42, "pre_rst1");
        #2;
        rst_i = 1'b1;
        #1;
        check("async_reset", result_o, 32'd0);
        check_vld("async_reset", 1'b0);
        sbq.delete();
        last_exp = '0;
        last_vld = 1'b0;
        @(posedge clk_i); #2;
        check("reset_held", result_o, 32'd0);
        rst_i = 1'b0;
        step(1, 1, MUL_, 32'd3, 32'd5, 32'd15, "post_rst0");
        step(1, 1, MULH_, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, "post_rst1");
        step(1, 0, MUL_, 32'd0, 32'd0, 32'd0, "post_rst2");
        step(1, 0, MUL_, 32'd0, 32'd0, 32'd0, "post_rst3");
        step(1, 0, MUL_, 32'd0, 32'd0, 32'd0, "post_rst4");

        // Randomised stream with occasional stalls, checked against the model
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            bit          en;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            en = ($urandom_range(0, 4) != 0);
            step(en, 1'b1, op, a, b, model(op, a, b), "random");
        end
        for (int i = 0; i < 4; i++)
            step(1, 0, MUL_, 32'd0, 32'd0, 32'd0, "drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
